// File: rtl/naive_dispatcher.sv
// Linear thread-ID dispatcher: one TID per enabled cycle from 0 to max_tid, with 3-D coordinates.
// Optional macro NAIVE_DISPATCHER_STALL_EN adds a stall input that gates dispatch like enable=0.
module naive_dispatcher #(
   parameter int TOTAL_TID = 512,
   parameter int TID_WIDTH = $clog2(TOTAL_TID)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 clr,
`ifdef NAIVE_DISPATCHER_STALL_EN
   input  logic                 stall,
`endif
   input  logic [TID_WIDTH-1:0] max_tid,
   input  logic [TID_WIDTH-1:0] ntid_x,
   input  logic [TID_WIDTH-1:0] ntid_y,
   input  logic [TID_WIDTH-1:0] ntid_z,
   output logic [TID_WIDTH-1:0] dispatch_tid,
   output logic [TID_WIDTH-1:0] tid_x,
   output logic [TID_WIDTH-1:0] tid_y,
   output logic [TID_WIDTH-1:0] tid_z,
   output logic                 tid_valid,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [TID_WIDTH-1:0] ONE = TID_WIDTH'(1);

   state_t               state, state_nxt;
   logic [TID_WIDTH-1:0] tid_nxt, x_nxt, y_nxt, z_nxt;
   logic                 valid_nxt, done_nxt;
   logic                 advance;

`ifdef NAIVE_DISPATCHER_STALL_EN
   assign advance = enable && !stall;
`else
   assign advance = enable;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         dispatch_tid <= '0;
         tid_x        <= '0;
         tid_y        <= '0;
         tid_z        <= '0;
         tid_valid    <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         dispatch_tid <= tid_nxt;
         tid_x        <= x_nxt;
         tid_y        <= y_nxt;
         tid_z        <= z_nxt;
         tid_valid    <= valid_nxt;
         done         <= done_nxt;
      end
   end

   // dispatch_tid always holds the most recently presented TID while in RUN,
   // so reaching max_tid means the final beat is already out.
   always_comb begin
      state_nxt = state;
      tid_nxt   = dispatch_tid;
      x_nxt     = tid_x;
      y_nxt     = tid_y;
      z_nxt     = tid_z;
      valid_nxt = 1'b0;
      done_nxt  = done;
      if (clr) begin
         state_nxt = IDLE;
         tid_nxt   = '0;
         x_nxt     = '0;
         y_nxt     = '0;
         z_nxt     = '0;
         done_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (advance) begin
                  state_nxt = RUN;
                  tid_nxt   = '0;
                  x_nxt     = '0;
                  y_nxt     = '0;
                  z_nxt     = '0;
                  valid_nxt = 1'b1;
                  done_nxt  = 1'b0;
               end
            end
            RUN: begin
               if (dispatch_tid == max_tid) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end else if (advance) begin
                  tid_nxt   = dispatch_tid + ONE;
                  valid_nxt = 1'b1;
                  if (tid_x == ntid_x) begin
                     x_nxt = '0;
                     if (tid_y == ntid_y) begin
                        y_nxt = '0;
                        z_nxt = (tid_z == ntid_z) ? '0 : tid_z + ONE;
                     end else begin
                        y_nxt = tid_y + ONE;
                     end
                  end else begin
                     x_nxt = tid_x + ONE;
                  end
               end
            end
            DONE: begin
               done_nxt = 1'b1;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_naive_dispatcher.sv
// Directed bench for naive_dispatcher: a reference model pushes expected beats to a
// scoreboard queue and a negedge monitor pops and compares every valid beat.
module tb_naive_dispatcher;

   localparam int W = 9;

   typedef struct {
      int tid;
      int x;
      int y;
      int z;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic         clr;
   logic         stall = 1'b0;
   logic [W-1:0] max_tid, ntid_x, ntid_y, ntid_z;
   logic [W-1:0] dispatch_tid, tid_x, tid_y, tid_z;
   logic         tid_valid, done;

   beat_t sb[$];
   int    errors = 0;
   int    checks = 0;
   int    mTid, mx, my, mz, mNx, mNy, mNz;
   int    lastTid, lastX, lastY, lastZ;
   int    b5x = -1, b5y = -1, b5z = -1;
   int    cyc;

   naive_dispatcher #(.TOTAL_TID(512)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .clr(clr),
`ifdef NAIVE_DISPATCHER_STALL_EN
      .stall(stall),
`endif
      .max_tid(max_tid),
      .ntid_x(ntid_x),
      .ntid_y(ntid_y),
      .ntid_z(ntid_z),
      .dispatch_tid(dispatch_tid),
      .tid_x(tid_x),
      .tid_y(tid_y),
      .tid_z(tid_z),
      .tid_valid(tid_valid),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_tid"}, 32'(dispatch_tid), 0);
      checkOutput({tag, "_x"}, 32'(tid_x), 0);
      checkOutput({tag, "_y"}, 32'(tid_y), 0);
      checkOutput({tag, "_z"}, 32'(tid_z), 0);
      checkOutput({tag, "_valid"}, 32'(tid_valid), 0);
      checkOutput({tag, "_done"}, 32'(done), 0);
   endtask

   task automatic applyStimulus(input logic en, input logic c);
      enable = en;
      clr    = c;
   endtask

   task automatic modelReset();
      mTid = 0; mx = 0; my = 0; mz = 0;
   endtask

   task automatic configure(input int mt, input int nx, input int ny, input int nz);
      max_tid = W'(mt);
      ntid_x  = W'(nx);
      ntid_y  = W'(ny);
      ntid_z  = W'(nz);
      mNx = nx; mNy = ny; mNz = nz;
      modelReset();
   endtask

   // Reference model: emit current coordinates, then step with cascading wrap.
   task automatic pushBeats(input int n);
      for (int i = 0; i < n; i++) begin
         sb.push_back('{mTid, mx, my, mz});
         mTid++;
         if (mx == mNx) begin
            mx = 0;
            if (my == mNy) begin
               my = 0;
               mz = (mz == mNz) ? 0 : mz + 1;
            end else my++;
         end else mx++;
      end
   endtask

   task automatic runToDone(input int limit, output int n);
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done_reached", 32'(done), 1);
   endtask

   task automatic restart(input string tag);
      applyStimulus(1'b0, 1'b1);
      @(negedge clk);
      checkAllZero(tag);
      applyStimulus(1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (tid_valid === 1'b1) begin
         beat_t e;
         if (sb.size() > 0) e = sb.pop_front();
         else e = '{-1, -1, -1, -1};
         checkOutput("beat_tid", 32'(dispatch_tid), e.tid);
         checkOutput("beat_x", 32'(tid_x), e.x);
         checkOutput("beat_y", 32'(tid_y), e.y);
         checkOutput("beat_z", 32'(tid_z), e.z);
         lastTid = int'(dispatch_tid);
         lastX = int'(tid_x); lastY = int'(tid_y); lastZ = int'(tid_z);
         if (dispatch_tid == W'(5)) begin
            b5x = int'(tid_x); b5y = int'(tid_y); b5z = int'(tid_z);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0);
      configure(0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1 checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("idle_hold_valid", 32'(tid_valid), 0);
      end

      // Linear sweep 0..255 with x tracking the TID
      configure(255, 255, 0, 0);
      pushBeats(256);
      applyStimulus(1'b1, 1'b0);
      runToDone(400, cyc);
      checkOutput("a_cycles", cyc, 257);
      checkOutput("a_valid_after", 32'(tid_valid), 0);
      checkOutput("a_sb_drained", sb.size(), 0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("a_done_sticky", 32'(done), 1);
         checkOutput("a_done_no_beat", 32'(tid_valid), 0);
      end

      // 4x2x2 block
      restart("b_clr");
      configure(15, 3, 1, 1);
      pushBeats(16);
      applyStimulus(1'b1, 1'b0);
      runToDone(100, cyc);
      checkOutput("b_cycles", cyc, 17);
      checkOutput("b_beat5_x", b5x, 1);
      checkOutput("b_beat5_y", b5y, 1);
      checkOutput("b_beat5_z", b5z, 0);
      checkOutput("b_last_tid", lastTid, 15);
      checkOutput("b_last_x", lastX, 3);
      checkOutput("b_last_y", lastY, 1);
      checkOutput("b_last_z", lastZ, 1);
      checkOutput("b_sb_drained", sb.size(), 0);

      // Enable gap after beat 10
      restart("c_clr");
      configure(40, 3, 3, 1);
      pushBeats(41);
      applyStimulus(1'b1, 1'b0);
      repeat (11) @(negedge clk);
      applyStimulus(1'b0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("c_gap_valid", 32'(tid_valid), 0);
         checkOutput("c_gap_hold", 32'(dispatch_tid), 10);
      end
      applyStimulus(1'b1, 1'b0);
      runToDone(100, cyc);
      checkOutput("c_cycles", cyc, 31);
      checkOutput("c_sb_drained", sb.size(), 0);

      // Clear at beat 100, then full restart
      restart("d_pre");
      configure(300, 15, 15, 1);
      pushBeats(101);
      applyStimulus(1'b1, 1'b0);
      repeat (101) @(negedge clk);
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      checkAllZero("d_clr");
      checkOutput("d_sb_partial", sb.size(), 0);
      modelReset();
      pushBeats(301);
      applyStimulus(1'b1, 1'b0);
      runToDone(400, cyc);
      checkOutput("d_cycles", cyc, 302);
      checkOutput("d_sb_drained", sb.size(), 0);

      // Single-beat run
      restart("e_clr");
      configure(0, 0, 0, 0);
      pushBeats(1);
      applyStimulus(1'b1, 1'b0);
      runToDone(10, cyc);
      checkOutput("e_cycles", cyc, 2);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i[0], 1'b0);
         @(negedge clk);
         checkOutput("e_no_beat", 32'(tid_valid), 0);
         checkOutput("e_done_sticky", 32'(done), 1);
      end
      checkOutput("e_sb_drained", sb.size(), 0);

      // Asynchronous reset mid-run
      restart("f_clr");
      configure(50, 7, 7, 0);
      pushBeats(51);
      applyStimulus(1'b1, 1'b0);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 checkAllZero("f_async");
      sb.delete();
      @(negedge clk);
      applyStimulus(1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("f_idle_valid", 32'(tid_valid), 0);
         checkOutput("f_idle_tid", 32'(dispatch_tid), 0);
      end
      modelReset();
      pushBeats(51);
      applyStimulus(1'b1, 1'b0);
      runToDone(100, cyc);
      checkOutput("f_cycles", cyc, 52);
      checkOutput("f_sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
